// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: launches the iterative multiplier for EX, stalls the pipe until the result returns,
// drains flushed operations, aborts hung ones on timeout and reuses the last result for repeated requests.
module mul_issue_ctrl #(
   parameter int TIMEOUT  = 64,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mul_valid,
   input  logic [1:0]  ex_mul_op,
   input  logic [31:0] ex_rs1_val,
   input  logic [31:0] ex_rs2_val,
   input  logic        flush,
   input  logic        mul_done,
   input  logic [31:0] mul_result,
   output logic        mul_start,
   output logic [1:0]  mul_opcode,
   output logic [31:0] mul_operand1,
   output logic [31:0] mul_operand2,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] result,
   output logic        mul_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic          c_valid;
   logic [1:0]    c_op;
   logic [31:0]   c_a, c_b, c_res;
   logic          req, hit;

   assign req = ex_mul_valid && !flush;
   assign hit = CACHE_EN && c_valid && c_op == ex_mul_op && c_a == ex_rs1_val && c_b == ex_rs2_val;
   assign stall = req && state != RESP;
   // A flush in the response cycle kills the writeback of that instruction.
   assign result_valid = state == RESP && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         mul_start    <= 1'b0;
         mul_opcode   <= '0;
         mul_operand1 <= '0;
         mul_operand2 <= '0;
         result       <= '0;
         mul_err      <= 1'b0;
         c_valid      <= 1'b0;
         c_op         <= '0;
         c_a          <= '0;
         c_b          <= '0;
         c_res        <= '0;
      end else begin
         mul_start <= 1'b0;
         case (state)
            IDLE: if (req) begin
               mul_opcode   <= ex_mul_op;
               mul_operand1 <= ex_rs1_val;
               mul_operand2 <= ex_rs2_val;
               if (hit) begin
                  result <= c_res;
                  state  <= RESP;
               end else begin
                  mul_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (flush) state <= DRAIN;
               else if (mul_done) begin
                  result  <= mul_result;
                  c_valid <= 1'b1;
                  c_op    <= mul_opcode;
                  c_a     <= mul_operand1;
                  c_b     <= mul_operand2;
                  c_res   <= mul_result;
                  state   <= RESP;
               end else if (cnt == TMAX) begin
                  mul_err <= 1'b1;
                  result  <= '0;
                  state   <= RESP;
               end
            end
            RESP: state <= IDLE;
            // The timeout budget keeps running from WAIT so a dead multiplier cannot wedge the drain.
            DRAIN: begin
               cnt <= cnt + 1'b1;
               if (mul_done) state <= IDLE;
               else if (cnt == TMAX) begin
                  mul_err <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: drives mul_issue_ctrl against a 34-cycle multiplier model and a last-result cache model.
module tb_mul_issue_ctrl;
   logic        clk = 1'b0, rst = 1'b1, ex_mul_valid = 1'b0, flush = 1'b0;
   logic [1:0]  ex_mul_op = '0;
   logic [31:0] ex_rs1_val = '0, ex_rs2_val = '0;
   logic        mul_done, mul_start, stall, result_valid, mul_err;
   logic [31:0] mul_result, mul_operand1, mul_operand2, result;
   logic [1:0]  mul_opcode;
   int checks = 0, failures = 0;
   logic        hang = 1'b0;
   int          cd = 0;
   logic [31:0] mres = '0;
   logic        m_valid = 1'b0;
   logic [1:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0;

   mul_issue_ctrl dut (
      .clk(clk), .rst(rst), .ex_mul_valid(ex_mul_valid), .ex_mul_op(ex_mul_op),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .flush(flush),
      .mul_done(mul_done), .mul_result(mul_result), .mul_start(mul_start),
      .mul_opcode(mul_opcode), .mul_operand1(mul_operand1), .mul_operand2(mul_operand2),
      .stall(stall), .result_valid(result_valid), .result(result), .mul_err(mul_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p = (op == 2'd0 || op == 2'd1) ? 64'(sa * sb) : (op == 2'd2) ? 64'(sa * ub) : 64'(ua * ub);
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   // Multiplier model: done pulse 34 cycles after the start pulse, unaffected by controller reset.
   always @(posedge clk) begin
      if (mul_start) begin
         cd   <= 34;
         mres <= ref_mul(mul_opcode, mul_operand1, mul_operand2);
      end else if (cd != 0) cd <= cd - 1;
   end
   assign mul_done   = !hang && cd == 1;
   assign mul_result = mres;

   task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int starts,
                         output int done_cyc, output int stall_bad, output logic err);
      bit got = 0;
      res = '0; lat = -1; starts = 0; done_cyc = -1; stall_bad = 0; err = 1'b0;
      @(negedge clk);
      ex_mul_valid = 1'b1; ex_mul_op = op; ex_rs1_val = a; ex_rs2_val = b;
      for (int c = 0; c < 300 && !got; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (mul_start) starts++;
         if (mul_done && done_cyc < 0) done_cyc = c;
         if (result_valid) begin
            got = 1; lat = c; res = result; err = mul_err;
            if (stall) stall_bad++;
         end else if (!stall) stall_bad++;
      end
      @(negedge clk);
      ex_mul_valid = 1'b0;
      if (!hang) begin
         m_valid = 1'b1; m_op = op; m_a = a; m_b = b;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({mul_start, result_valid, mul_err, stall} !== 4'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", {mul_start, result_valid, mul_err, stall});
      end
      checks++;
      if ({mul_opcode, mul_operand1, mul_operand2, result} !== 98'd0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {mul_opcode, mul_operand1, mul_operand2, result});
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({result_valid, stall, mul_start} !== 3'b0) begin
         failures++; $display("FAIL idle_after_reset got=%b exp=000", {result_valid, stall, mul_start});
      end
   endtask

   task automatic test_mul_basic;
      logic [31:0] r; int lat, st, dc, sb; logic e;
      do_req(2'd0, 32'd7, 32'd6, r, lat, st, dc, sb, e);
      checks++; if (r !== 32'd42) begin failures++; $display("FAIL basic_result got=%0d exp=42", r); end
      checks++; if (st !== 1) begin failures++; $display("FAIL basic_starts got=%0d exp=1", st); end
      checks++; if (lat !== 36) begin failures++; $display("FAIL basic_latency got=%0d exp=36", lat); end
      checks++; if (lat - dc !== 1) begin failures++; $display("FAIL basic_done_to_valid got=%0d exp=1", lat - dc); end
      checks++; if (sb !== 0) begin failures++; $display("FAIL basic_stall got=%0d bad cycles exp=0", sb); end
   endtask

   task automatic test_cache_hit;
      logic [31:0] r; int lat, st, dc, sb; logic e;
      do_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st, dc, sb, e);
      checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL hit_first_result got=%h exp=fffffffe", r); end
      checks++; if (st !== 1 || lat !== 36) begin failures++; $display("FAIL hit_first_launch got=%0d/%0d exp=1/36", st, lat); end
      do_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st, dc, sb, e);
      checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL hit_second_result got=%h exp=fffffffe", r); end
      checks++; if (st !== 0) begin failures++; $display("FAIL hit_second_starts got=%0d exp=0", st); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL hit_second_latency got=%0d exp=1", lat); end
      checks++; if (sb !== 0) begin failures++; $display("FAIL hit_stall got=%0d bad cycles exp=0", sb); end
   endtask

   task automatic test_opcode_miss;
      logic [31:0] r; int lat, st, dc, sb; logic e;
      do_req(2'd0, 32'd3, 32'd5, r, lat, st, dc, sb, e);
      checks++; if (r !== 32'd15) begin failures++; $display("FAIL opmiss_mul got=%0d exp=15", r); end
      do_req(2'd3, 32'd3, 32'd5, r, lat, st, dc, sb, e);
      checks++; if (st !== 1 || lat !== 36) begin failures++; $display("FAIL opmiss_launch got=%0d/%0d exp=1/36", st, lat); end
      checks++; if (r !== 32'd0) begin failures++; $display("FAIL opmiss_mulhu got=%h exp=0", r); end
   endtask

   task automatic test_random;
      logic [31:0] r, a = '0, b = '0, exp; int lat, st, dc, sb; logic e, hit;
      logic [1:0] op = '0;
      for (int i = 0; i < 24; i++) begin
         if (i == 0 || $urandom_range(0, 2) != 0) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
         end
         hit = m_valid && m_op == op && m_a == a && m_b == b;
         exp = ref_mul(op, a, b);
         do_req(op, a, b, r, lat, st, dc, sb, e);
         checks++;
         if (r !== exp || lat !== (hit ? 1 : 36) || st !== (hit ? 0 : 1) || sb !== 0) begin
            failures++;
            $display("FAIL rand_%0d op=%0d a=%h b=%h got res=%h lat=%0d starts=%0d stallbad=%0d exp res=%h lat=%0d starts=%0d",
                     i, op, a, b, r, lat, st, sb, exp, hit ? 1 : 36, hit ? 0 : 1);
         end
      end
      checks++; if (mul_err !== 1'b0) begin failures++; $display("FAIL rand_err got=%b exp=0", mul_err); end
   endtask

   task automatic test_flush_drain;
      logic [31:0] r = '0; int first_rv = -1, starts = 0, old_done = -1, stall_bad = 0, lat, st, dc, sb; logic e;
      @(negedge clk);
      ex_mul_valid = 1'b1; ex_mul_op = 2'd0; ex_rs1_val = 32'd11; ex_rs2_val = 32'd13;
      for (int c = 0; c < 300 && first_rv < 0; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 12) flush = 1'b1;
         if (c == 13) begin flush = 1'b0; ex_rs1_val = 32'd4; ex_rs2_val = 32'd9; end
         #1;
         if (mul_start) starts++;
         if (mul_done && old_done < 0) old_done = c;
         if (result_valid) begin first_rv = c; r = result; end
         if (c >= 13 && (old_done < 0 || c <= old_done) && !stall) stall_bad++;
      end
      @(negedge clk);
      ex_mul_valid = 1'b0;
      m_valid = 1'b1; m_op = 2'd0; m_a = 32'd4; m_b = 32'd9;
      checks++; if (old_done !== 35) begin failures++; $display("FAIL drain_old_done got=%0d exp=35", old_done); end
      checks++; if (first_rv !== 72) begin failures++; $display("FAIL drain_first_valid got=%0d exp=72", first_rv); end
      checks++; if (starts !== 2) begin failures++; $display("FAIL drain_starts got=%0d exp=2", starts); end
      checks++; if (r !== 32'd36) begin failures++; $display("FAIL drain_new_result got=%0d exp=36", r); end
      checks++; if (stall_bad !== 0) begin failures++; $display("FAIL drain_stall got=%0d bad cycles exp=0", stall_bad); end
      do_req(2'd0, 32'd11, 32'd13, r, lat, st, dc, sb, e);
      checks++; if (st !== 1 || lat !== 36) begin failures++; $display("FAIL flushed_not_cached got=%0d/%0d exp=1/36", st, lat); end
      checks++; if (r !== 32'd143) begin failures++; $display("FAIL flushed_reissue got=%0d exp=143", r); end
   endtask

   task automatic test_timeout;
      logic [31:0] r; int lat, st, dc, sb; logic e;
      hang = 1'b1;
      do_req(2'd0, 32'd2, 32'd3, r, lat, st, dc, sb, e);
      hang = 1'b0;
      checks++; if (lat !== 66) begin failures++; $display("FAIL timeout_latency got=%0d exp=66", lat); end
      checks++; if (r !== 32'd0) begin failures++; $display("FAIL timeout_result got=%h exp=0", r); end
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", e); end
      do_req(2'd0, 32'd2, 32'd3, r, lat, st, dc, sb, e);
      checks++; if (st !== 1 || r !== 32'd6) begin failures++; $display("FAIL timeout_not_cached got=%0d/%0d exp=1/6", st, r); end
      checks++; if (mul_err !== 1'b1) begin failures++; $display("FAIL timeout_err_sticky got=%b exp=1", mul_err); end
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] r; int lat, st, dc, sb, rv = 0, starts = 0, dones = 0; logic e;
      @(negedge clk);
      ex_mul_valid = 1'b1; ex_mul_op = 2'd3; ex_rs1_val = 32'd100; ex_rs2_val = 32'd200;
      repeat (8) @(negedge clk);
      rst = 1'b1; ex_mul_valid = 1'b0;
      #1;
      checks++;
      if ({mul_start, result_valid, mul_err, stall} !== 4'b0) begin
         failures++; $display("FAIL midrst_flags got=%b exp=0000", {mul_start, result_valid, mul_err, stall});
      end
      checks++;
      if ({mul_opcode, mul_operand1, mul_operand2, result} !== 98'd0) begin
         failures++; $display("FAIL midrst_data got=%h exp=0", {mul_opcode, mul_operand1, mul_operand2, result});
      end
      @(negedge clk);
      rst = 1'b0; m_valid = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         #1;
         if (result_valid) rv++;
         if (mul_start) starts++;
         if (mul_done) dones++;
      end
      checks++; if (rv !== 0 || starts !== 0) begin failures++; $display("FAIL stray_done got rv=%0d starts=%0d exp=0/0", rv, starts); end
      checks++; if (dones !== 1) begin failures++; $display("FAIL stray_done_seen got=%0d exp=1", dones); end
      do_req(2'd0, 32'd2, 32'd3, r, lat, st, dc, sb, e);
      checks++; if (st !== 1 || lat !== 36 || r !== 32'd6) begin
         failures++; $display("FAIL cache_cleared got starts=%0d lat=%0d res=%0d exp=1/36/6", st, lat, r);
      end
   endtask

   initial begin
      test_reset;
      test_mul_basic;
      test_cache_hit;
      test_opcode_miss;
      test_random;
      test_flush_drain;
      test_timeout;
      test_reset_mid_wait;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
